// File: rtl/exu_wb_arbiter.sv
// EXU writeback arbiter: one holding buffer per result producer, drained round-robin
// onto the single registered register-file write port; also answers decode hazard queries.

module exu_wb_hold_buf #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic            grant,
  input  logic [XLEN-1:0] in_data,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic [AW-1:0]   rd,
  output logic            hit1,
  output logic            hit2
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      rd    <= '0;
    end else if (accept) begin
      // a refill on the drain cycle wins: the old entry is already on its way out
      valid <= 1'b1;
      data  <= in_data;
      rd    <= in_rd;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

  assign hit1 = valid && (rd == q_rs1) && (q_rs1 != '0);
  assign hit2 = valid && (rd == q_rs2) && (q_rs2 != '0);
endmodule

module exu_wb_arbiter #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       req_valid,
  output logic [3:0]                       req_ready,
  input  logic [4*XLEN-1:0]                req_data,
  input  logic [4*REG_FILE_ADDR_WIDTH-1:0] req_rd_addr,
  output logic [XLEN-1:0]                  exu_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0]   exu_wb_rd_addr,
  output logic                             exu_wb_rd_wr_en,
  output logic [1:0]                       wb_src_id,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]   q_rs1_addr,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]   q_rs2_addr,
  output logic                             q_rs1_pending,
  output logic                             q_rs2_pending,
  output logic                             arb_busy
);
  localparam int NUM_LANES = 4;
  localparam int AW        = REG_FILE_ADDR_WIDTH;

  logic [NUM_LANES-1:0]           buf_valid;
  logic [NUM_LANES-1:0][XLEN-1:0] buf_data;
  logic [NUM_LANES-1:0][AW-1:0]   buf_rd;
  logic [NUM_LANES-1:0]           hit1, hit2;
  logic [NUM_LANES-1:0]           grant, accept;
  logic [1:0]                     ptr, grant_idx, idx;
  logic                           grant_any;

  // round-robin search starting at ptr; 2-bit index arithmetic gives the 3->0 wrap
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    idx       = ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + 2'(k);
      if (!grant_any && buf_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    for (int i = 0; i < NUM_LANES; i++)
      grant[i] = grant_any && (grant_idx == 2'(i));
  end

  assign req_ready = ~buf_valid | grant | {NUM_LANES{rst}};
  assign accept    = req_valid & req_ready & {NUM_LANES{~rst}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    exu_wb_hold_buf #(.XLEN(XLEN), .AW(AW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept[i]),
      .grant   (grant[i]),
      .in_data (req_data[i*XLEN +: XLEN]),
      .in_rd   (req_rd_addr[i*AW +: AW]),
      .q_rs1   (q_rs1_addr),
      .q_rs2   (q_rs2_addr),
      .valid   (buf_valid[i]),
      .data    (buf_data[i]),
      .rd      (buf_rd[i]),
      .hit1    (hit1[i]),
      .hit2    (hit2[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      exu_wb_data     <= '0;
      exu_wb_rd_addr  <= '0;
      wb_src_id       <= '0;
      exu_wb_rd_wr_en <= 1'b0;
    end else if (grant_any) begin
      ptr             <= grant_idx + 2'd1;
      exu_wb_data     <= buf_data[grant_idx];
      exu_wb_rd_addr  <= buf_rd[grant_idx];
      wb_src_id       <= grant_idx;
      // x0 results still use the slot but must not strobe the register file
      exu_wb_rd_wr_en <= (buf_rd[grant_idx] != '0);
    end else begin
      exu_wb_rd_wr_en <= 1'b0;
    end
  end

  // the writeback register is not searched: WB forwarding covers it
  assign q_rs1_pending = |hit1;
  assign q_rs2_pending = |hit2;
  assign arb_busy      = |buf_valid;
endmodule
